// File: rtl/manual_set_button_conditioner.sv
// Manual-set button conditioning for the century clock:
// sync, debounce, press pulse and auto-repeat per button.

module manual_set_button_path #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 2,
  parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic manual_mode,
  input  logic btn_raw,
  output logic pulse,
  output logic held_next
);

  localparam int M1 = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                      DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MX = (M1 > REPEAT_PERIOD) ? M1 : REPEAT_PERIOD;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic          REL_LVL = BTN_ACTIVE_HIGH ? 1'b0 : 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    HOLD     = 3'd2,
    REPEAT   = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q, sync_d;
  logic          pulse_q, pulse_d;
  logic          p;

  // Sync chain resets to the raw released level so reset never looks like a press.
  assign sync_d = {sync_q[0], btn_raw};
  assign p      = BTN_ACTIVE_HIGH ? sync_q[1] : ~sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    pulse_d = 1'b0;
    if (!manual_mode) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (p) state_d = DB_PRESS;
        end
        DB_PRESS: begin
          if (!p) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end
        end
        HOLD: begin
          if (!p) begin
            state_d = DB_REL;
            cnt_d   = '0;
          end else if (cnt_q == RD_LAST) begin
            state_d = REPEAT;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end
        end
        REPEAT: begin
          if (!p) begin
            state_d = DB_REL;
            cnt_d   = '0;
          end else if (cnt_q == RP_LAST) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
          end
        end
        DB_REL: begin
          if (p) begin
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign held_next = (state_d == HOLD) || (state_d == REPEAT);
  assign pulse     = pulse_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= {2{REL_LVL}};
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

module manual_set_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 2,
  parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic manual_mode,
  input  logic btn_ss_yy_raw,
  input  logic btn_min_mon_raw,
  input  logic btn_hh_dd_raw,
  output logic manual_ss_yy_en,
  output logic manual_min_mon_en,
  output logic manual_hh_dd_en,
  output logic any_held
);

  logic [2:0] raw;
  logic [2:0] pulse;
  logic [2:0] held_next;
  logic       any_held_q, any_held_d;

  assign raw = {btn_hh_dd_raw, btn_min_mon_raw, btn_ss_yy_raw};

  for (genvar i = 0; i < 3; i++) begin : g_path
    manual_set_button_path #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .BTN_ACTIVE_HIGH(BTN_ACTIVE_HIGH)
    ) u_path (
      .clk        (clk),
      .rst        (rst),
      .manual_mode(manual_mode),
      .btn_raw    (raw[i]),
      .pulse      (pulse[i]),
      .held_next  (held_next[i])
    );
  end

  assign any_held_d = |held_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) any_held_q <= 1'b0;
    else      any_held_q <= any_held_d;
  end

  assign manual_ss_yy_en   = pulse[0];
  assign manual_min_mon_en = pulse[1];
  assign manual_hh_dd_en   = pulse[2];
  assign any_held          = any_held_q;

endmodule

// File: tb/tb_manual_set_button_conditioner.sv
// Bench for manual_set_button_conditioner: active-high and active-low
// instances driven with the same presses, checked against a run-length model.

module tb_manual_set_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       mode  = 1'b1;
  logic [2:0] press = 3'b000;

  logic h_ss, h_mm, h_hd, h_any;
  logic l_ss, l_mm, l_hd, l_any;

  int checks = 0;
  int errors = 0;

  // Model: 0 = waiting for press, 1 = held, 2 = releasing
  int   st  [3];
  int   run [3];
  logic h1  [3];
  logic h2  [3];
  logic [2:0] exp_p;
  logic       exp_any;
  int   edge_n;
  int   first;

  always #5 clk = ~clk;

  manual_set_button_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .BTN_ACTIVE_HIGH(1'b1)
  ) u_h (
    .clk(clk), .rst(rst), .manual_mode(mode),
    .btn_ss_yy_raw(press[0]),
    .btn_min_mon_raw(press[1]),
    .btn_hh_dd_raw(press[2]),
    .manual_ss_yy_en(h_ss),
    .manual_min_mon_en(h_mm),
    .manual_hh_dd_en(h_hd),
    .any_held(h_any)
  );

  manual_set_button_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .BTN_ACTIVE_HIGH(1'b0)
  ) u_l (
    .clk(clk), .rst(rst), .manual_mode(mode),
    .btn_ss_yy_raw(~press[0]),
    .btn_min_mon_raw(~press[1]),
    .btn_hh_dd_raw(~press[2]),
    .manual_ss_yy_en(l_ss),
    .manual_min_mon_en(l_mm),
    .manual_hh_dd_en(l_hd),
    .any_held(l_any)
  );

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      st[i]  = 0;
      run[i] = 0;
      h1[i]  = 1'b0;
      h2[i]  = 1'b0;
    end
    exp_p   = 3'b000;
    exp_any = 1'b0;
  endfunction

  function automatic void model_step(input logic [2:0] pr,
                                     input logic md);
    logic p;
    exp_any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p        = h2[i];
      h2[i]    = h1[i];
      h1[i]    = pr[i];
      exp_p[i] = 1'b0;
      if (!md) begin
        st[i]  = 0;
        run[i] = 0;
      end else if (st[i] == 0) begin
        // accept after D+1 consecutive pressed samples
        run[i] = p ? run[i] + 1 : 0;
        if (run[i] == D + 1) begin
          exp_p[i] = 1'b1;
          st[i]    = 1;
          run[i]   = 0;
        end
      end else if (st[i] == 1) begin
        if (!p) begin
          st[i]  = 2;
          run[i] = 0;
        end else begin
          run[i] = run[i] + 1;
          if (run[i] == RD ||
              (run[i] > RD && (run[i] - RD) % RP == 0))
            exp_p[i] = 1'b1;
        end
      end else begin
        if (p) run[i] = 0;
        else begin
          run[i] = run[i] + 1;
          if (run[i] == D) begin
            st[i]  = 0;
            run[i] = 0;
          end
        end
      end
      if (st[i] == 1) exp_any = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b",
             tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("h_ss_yy",   h_ss,  exp_p[0]);
    chk("h_min_mon", h_mm,  exp_p[1]);
    chk("h_hh_dd",   h_hd,  exp_p[2]);
    chk("h_any",     h_any, exp_any);
    chk("l_ss_yy",   l_ss,  exp_p[0]);
    chk("l_min_mon", l_mm,  exp_p[1]);
    chk("l_hh_dd",   l_hd,  exp_p[2]);
    chk("l_any",     l_any, exp_any);
  endtask

  task automatic cycle(input logic [2:0] pr, input logic md);
    press = pr;
    mode  = md;
    @(posedge clk);
    model_step(pr, md);
    edge_n++;
    #1;
    check_all();
  endtask

  task automatic hold(input logic [2:0] pr, input int n);
    repeat (n) cycle(pr, 1'b1);
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check_all();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] lvl;
    logic       md;

    // reset with every button pressed
    press = 3'b111;
    mode  = 1'b1;
    model_reset();
    #3;
    check_all();
    #9;
    check_all();

    // release reset, hold min_mon: first pulse on edge 7
    press  = 3'b010;
    rst    = 1'b1;
    edge_n = 0;
    first  = -1;
    repeat (14) begin
      cycle(3'b010, 1'b1);
      if (first < 0 && h_mm === 1'b1) first = edge_n;
    end
    checks++;
    assert (first == 7) else begin
      errors++;
      $error("FAIL first_pulse_edge observed=%0d expected=7",
             first);
    end
    hold(3'b000, 12);

    // bounce on ss_yy
    cycle(3'b001, 1'b1);
    cycle(3'b000, 1'b1);
    cycle(3'b001, 1'b1);
    cycle(3'b000, 1'b1);
    hold(3'b000, 10);

    // long hold on hh_dd, then release glitch
    hold(3'b100, 27);
    hold(3'b000, 3);
    hold(3'b100, 2);
    hold(3'b000, 12);

    // gating mid-repeat, button kept held
    hold(3'b001, 20);
    repeat (3) cycle(3'b001, 1'b0);
    hold(3'b001, 15);
    hold(3'b000, 12);

    // all three together
    hold(3'b111, 25);
    hold(3'b000, 12);

    // reset mid-repeat
    hold(3'b111, 15);
    async_reset();
    hold(3'b111, 10);
    hold(3'b000, 12);

    // random presses and mode drops
    lvl = 3'b000;
    repeat (800) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 9) == 0) lvl[i] = ~lvl[i];
      md = ($urandom_range(0, 49) != 0);
      cycle(lvl, md);
    end
    hold(3'b000, 12);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
